ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Front-end controller for the keyboard path: samples the raw PS/2 clock/data lines and assembles 11-bit frames.
- Sequences the make/break/extended prefix protocol (E0, F0) and queues one decoded key event per keystroke transition.
- Events go into a small first-word-fall-through FIFO read by the CPU-side bus logic; the scan-code-to-ASCII stage consumes key_code from here.

Parameters:
- AW, 3, FIFO address width; depth = 2^AW entries.
- TIMEOUT, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_data  in  1  raw PS/2 data (asynchronous)
- rd_en  in  1  pop head entry; ignored when key_valid=0
- clr_err  in  1  clear sticky error flags
- key_code  out  8  head entry scan code
- key_ext  out  1  head entry had E0 prefix
- key_brk  out  1  head entry is a break (release)
- key_valid  out  1  FIFO not empty
- fifo_count  out  AW+1  number of stored entries
- frame_err  out  1  sticky: parity, stop-bit or timeout error
- overflow  out  1  sticky: event dropped because FIFO full

Behaviour:
- Reset (async, rst=1): all outputs 0; both FSMs idle; FIFO pointers, bit counter and watchdog cleared. Any frame in progress is discarded.
- Input synchronisation: ps2_clk and ps2_data each pass through 2 flip-flops. A falling edge (fe) is synchronised clk previous=1, current=0. Data is sampled on fe.
- Frame FSM, states F_IDLE and F_RECV with bit counter 0..10:
  - F_IDLE: fe with data=0 -> F_RECV, cnt=1. fe with data=1 is ignored.
  - F_RECV: each fe shifts data in LSB first. cnt 1-8 are data bits, cnt 9 is parity, cnt 10 is stop.
  - On the stop-bit fe the FSM returns to F_IDLE. The byte is good only if (data bits + parity) has an odd number of 1s and stop=1.
  - Good byte: byte_vld pulses 1 cycle, registered one cycle after the stop-bit fe.
  - Bad byte: frame_err is set and nothing is passed on.
- Watchdog: the counter increments every clk in F_RECV and clears on each fe. Reaching TIMEOUT sets frame_err and returns to F_IDLE.
- Decode FSM, states D_IDLE, D_EXT, D_BRK, D_EXT_BRK, advancing on byte_vld:
  - D_IDLE: E0 -> D_EXT; F0 -> D_BRK; any other byte -> push {ext=0, brk=0, byte}.
  - D_EXT: E0 -> stay in D_EXT; F0 -> D_EXT_BRK; any other byte -> push {1, 0, byte} -> D_IDLE.
  - D_BRK: any byte -> push {0, 1, byte} -> D_IDLE.
  - D_EXT_BRK: any byte -> push {1, 1, byte} -> D_IDLE.
  - Prefixes are never queued. A frame error does not reset the decode state.
- FIFO:
  - 2^AW entries x 10 bits; wptr/rptr are AW bits and wrap modulo depth. fifo_count is tracked explicitly, so full means count = 2^AW.
  - Push occurs in the byte_vld cycle; key_valid and fifo_count update on the next clk. Total latency is 2 clk from the stop-bit fe to key_valid.
  - key_code, key_ext and key_brk always show the head entry (FWFT) and are 0 when the FIFO is empty.
  - rd_en with key_valid=1 advances rptr; the new head is visible on the next cycle.
  - Push while full: entry dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push with rd_en while empty: rd_en ignored, push succeeds.
- Sticky flags: clr_err clears frame_err and overflow. A new error in the same cycle as clr_err wins, so the flag stays 1.

Test Plan:
- Make code 'a': frame start=0, data 0x1C LSB first (0,0,1,1,1,0,0,0), parity=0, stop=1 -> key_valid=1 two clk after the stop fe; key_code=0x1C, ext=0, brk=0; fifo_count=1. rd_en for one cycle -> key_valid=0, key_code=0x00.
- Extended break, frames E0, F0, 75 -> exactly one entry, key_code=0x75, ext=1, brk=1; fifo_count=1.
- Parity error: 0x1C frame with parity=1 -> no push, frame_err=1. Then clr_err -> frame_err=0. Then a good 0x1C frame is queued normally.
- Overflow, AW=3: nine make codes 0x16, 0x1E, ..., no reads -> fifo_count=8, overflow=1, head=0x16. Eight pops return the first eight codes in order. Also check a push with simultaneous rd_en while full -> no overflow, count stays 8.
- Timeout, TIMEOUT=100 for this test: start bit plus 4 data bits, then ps2_clk held high -> frame_err=1 at ~100 clk, frame FSM idle. A following full 0x1C frame is decoded correctly.
- Reset mid-operation: rst asserted after 6 bits of a frame with 3 entries queued -> all outputs 0 immediately (async). After deassert, a fresh 0x29 frame yields key_code=0x29, fifo_count=1.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: line synchroniser, 11-bit frame receiver with watchdog,
// E0/F0 prefix decoder and a first-word-fall-through event FIFO.
module ps2_key_ctrl #(
    parameter int AW      = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [7:0]    key_code,
    output logic          key_ext,
    output logic          key_brk,
    output logic          key_valid,
    output logic [AW:0]   fifo_count,
    output logic          frame_err,
    output logic          overflow
);
    localparam int DEPTH = 1 << AW;
    localparam int WDW   = $clog2(TIMEOUT + 1);

    typedef enum logic {F_IDLE, F_RECV} fstate_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dstate_t;

    logic [1:0]     ps2_clk_sync_q, ps2_data_sync_q;
    logic           ps2_clk_prev_q;
    logic           fe, bit_in;

    fstate_t        fstate_q;
    logic [3:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           parity_q;
    logic [WDW-1:0] wdog_q;
    logic           byte_vld_q;
    logic           frame_err_q;

    dstate_t        dstate_q, dstate_d;
    logic           push, push_ext, push_brk;

    logic [9:0]     mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    count_q;
    logic           overflow_q;
    logic           full, pop, wr;
    logic [9:0]     head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_sync_q  <= '0;
            ps2_data_sync_q <= '0;
            ps2_clk_prev_q  <= 1'b0;
        end else begin
            ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk};
            ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data};
            ps2_clk_prev_q  <= ps2_clk_sync_q[1];
        end
    end

    assign fe     = ps2_clk_prev_q & ~ps2_clk_sync_q[1];
    assign bit_in = ps2_data_sync_q[1];

    // Frame receiver; bit_cnt 1-8 data, 9 parity, 10 stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate_q    <= F_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            wdog_q      <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= frame_err_q & ~clr_err;
            case (fstate_q)
                F_IDLE: begin
                    wdog_q <= '0;
                    if (fe && !bit_in) begin
                        fstate_q  <= F_RECV;
                        bit_cnt_q <= 4'd1;
                    end
                end
                F_RECV: begin
                    if (fe) begin
                        wdog_q    <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q <= 4'd8) begin
                            shift_q <= {bit_in, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd9) begin
                            parity_q <= bit_in;
                        end else begin
                            fstate_q  <= F_IDLE;
                            bit_cnt_q <= '0;
                            if ((^{shift_q, parity_q}) && bit_in) begin
                                byte_vld_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        wdog_q      <= '0;
                        bit_cnt_q   <= '0;
                        fstate_q    <= F_IDLE;
                        frame_err_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: fstate_q <= F_IDLE;
            endcase
        end
    end

    // Push is combinational on byte_vld so the event lands in the FIFO the same cycle.
    always_comb begin
        dstate_d = dstate_q;
        push     = 1'b0;
        push_ext = 1'b0;
        push_brk = 1'b0;
        if (byte_vld_q) begin
            case (dstate_q)
                D_IDLE: begin
                    if (shift_q == 8'hE0)      dstate_d = D_EXT;
                    else if (shift_q == 8'hF0) dstate_d = D_BRK;
                    else                       push = 1'b1;
                end
                D_EXT: begin
                    if (shift_q == 8'hF0) begin
                        dstate_d = D_EXT_BRK;
                    end else if (shift_q != 8'hE0) begin
                        push     = 1'b1;
                        push_ext = 1'b1;
                        dstate_d = D_IDLE;
                    end
                end
                D_BRK: begin
                    push     = 1'b1;
                    push_brk = 1'b1;
                    dstate_d = D_IDLE;
                end
                default: begin
                    push     = 1'b1;
                    push_ext = 1'b1;
                    push_brk = 1'b1;
                    dstate_d = D_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dstate_q <= D_IDLE;
        else     dstate_q <= dstate_d;
    end

    assign full = (count_q == (AW + 1)'(DEPTH));
    assign pop  = rd_en && (count_q != '0);
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= {push_ext, push_brk, shift_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (wr && !pop)      count_q <= count_q + 1'b1;
            else if (!wr && pop) count_q <= count_q - 1'b1;
            overflow_q <= (overflow_q & ~clr_err) | (push & full & ~pop);
        end
    end

    assign head       = mem_q[rptr_q];
    assign key_valid  = (count_q != '0);
    assign key_code   = key_valid ? head[7:0] : 8'h00;
    assign key_brk    = key_valid & head[8];
    assign key_ext    = key_valid & head[9];
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: bit-banged PS/2 frames with hand-computed results.
module tb_ps2_key_ctrl;
    localparam int AW   = 3;
    localparam int HALF = 10;

    logic          clk = 1'b0;
    logic          rst, ps2_clk, ps2_data, rd_en, clr_err;
    logic [7:0]    key_code;
    logic          key_ext, key_brk, key_valid, frame_err, overflow;
    logic [AW:0]   fifo_count;

    int n_vec = 0;
    int n_err = 0;

    ps2_key_ctrl #(.AW(AW), .TIMEOUT(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_brk    (key_brk),
        .key_valid  (key_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    // Stop bit is driven by hand so rd_en can land exactly in the byte_vld cycle.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic rd_at_push, input logic chk_lat);
        logic [10:0] bits;
        bits = mk_frame(b, bad_par);
        send_bits(bits, 10);
        @(negedge clk) ps2_data = bits[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (chk_lat) check("lat_before", {15'd0, key_valid}, 16'd0);
        @(negedge clk) rd_en = rd_at_push;
        @(posedge clk);
        #1;
        if (chk_lat) check("lat_at2", {15'd0, key_valid}, 16'd1);
        @(negedge clk) rd_en = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp_code);
        @(negedge clk);
        check(tag, {8'd0, key_code}, {8'd0, exp_code});
        rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
    endtask

    logic [7:0] codes [9];

    initial begin
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check("rst_count", {12'd0, fifo_count}, 16'd0);
        check("rst_flags", {13'd0, frame_err, overflow, key_code != 8'h00}, 16'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // make code 'a' with latency check
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        check("a_code", {8'd0, key_code}, 16'h001C);
        check("a_extbrk", {14'd0, key_ext, key_brk}, 16'd0);
        check("a_count", {12'd0, fifo_count}, 16'd1);
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        check("a_pop_valid", {15'd0, key_valid}, 16'd0);
        check("a_pop_code", {8'd0, key_code}, 16'd0);

        // extended break E0 F0 75
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        check("eb_e0_none", {12'd0, fifo_count}, 16'd0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        check("eb_count", {12'd0, fifo_count}, 16'd1);
        check("eb_code", {8'd0, key_code}, 16'h0075);
        check("eb_extbrk", {14'd0, key_ext, key_brk}, 16'd3);
        pop_chk("eb_pop", 8'h75);

        // plain break F0 1C then parity error
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("brk_extbrk", {14'd0, key_ext, key_brk}, 16'd1);
        pop_chk("brk_pop", 8'h1C);
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check("par_err", {15'd0, frame_err}, 16'd1);
        check("par_count", {12'd0, fifo_count}, 16'd0);
        pulse_clr();
        check("par_clr", {15'd0, frame_err}, 16'd0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("par_good", {8'd0, key_code}, 16'h001C);
        check("par_good_ext", {14'd0, key_ext, key_brk}, 16'd0);
        pop_chk("par_pop", 8'h1C);

        // overflow
        for (int i = 0; i < 9; i++) send_frame(codes[i], 1'b0, 1'b0, 1'b0);
        check("ovf_count", {12'd0, fifo_count}, 16'd8);
        check("ovf_flag", {15'd0, overflow}, 16'd1);
        check("ovf_head", {8'd0, key_code}, 16'h0016);
        pulse_clr();
        check("ovf_clr", {15'd0, overflow}, 16'd0);
        send_frame(8'h4E, 1'b0, 1'b1, 1'b0);
        check("full_rw_count", {12'd0, fifo_count}, 16'd8);
        check("full_rw_ovf", {15'd0, overflow}, 16'd0);
        for (int i = 1; i < 8; i++) pop_chk("ovf_pop", codes[i]);
        pop_chk("ovf_pop_last", 8'h4E);
        check("ovf_empty", {12'd0, fifo_count}, 16'd0);

        // watchdog timeout: start + 4 data bits, then idle
        send_bits(mk_frame(8'h1C, 1'b0), 5);
        repeat (40) @(negedge clk);
        check("to_early", {15'd0, frame_err}, 16'd0);
        repeat (80) @(negedge clk);
        check("to_err", {15'd0, frame_err}, 16'd1);
        pulse_clr();
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("to_after_code", {8'd0, key_code}, 16'h001C);
        check("to_after_err", {15'd0, frame_err}, 16'd0);
        pop_chk("to_pop", 8'h1C);

        // reset mid-frame with 3 queued entries and a sticky error
        for (int i = 0; i < 3; i++) send_frame(codes[i], 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", {12'd0, fifo_count}, 16'd3);
        send_bits(mk_frame(8'h33, 1'b0), 6);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", {15'd0, key_valid}, 16'd0);
        check("arst_count", {12'd0, fifo_count}, 16'd0);
        check("arst_rest", {8'd0, key_code | {5'd0, key_ext, key_brk, frame_err | overflow}}, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("post_rst_code", {8'd0, key_code}, 16'h0029);
        check("post_rst_count", {12'd0, fifo_count}, 16'd1);
        check("post_rst_err", {15'd0, frame_err}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
